timer_mc: RTL and testbench
===========================

# timer_mc

Parametrised multi-channel interval timer. It is the next-generation Avalon-MM timer peripheral for the Nios II subsystem. It provides NUM_CH independent down-counters of COUNTER_W bits, each with its own period, control, status and snapshot registers. It drives one combined level interrupt to the processor.

## Interface
- NUM_CH, default 2: number of channels, 1..8.
- COUNTER_W, default 32: counter and period width, 8..DATA_W.
- DATA_W, default 32: Avalon data width, 16 or 32.
- PERIOD_RST, default 49999: reset value of every period register and counter.
- Address width AW = clog2(NUM_CH)+2, derived, not overridable.
- `clk` in, 1 bit: single clock.
- `reset_n` in, 1 bit: asynchronous, active-low reset.
- `address` in, AW bits: word address; {channel, offset[1:0]}.
- `chipselect` in, 1 bit: slave select.
- `write_n` in, 1 bit: active-low write.
- `writedata` in, DATA_W bits: write data.
- `readdata` out, DATA_W bits: registered read data.
- `irq` out, 1 bit: OR of all channel interrupts.

## Operation
- Per-channel register offsets:
  - 0 STATUS: bit0 TO, bit1 RUN. Any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT. Write bit2 = START, write bit3 = STOP. Bits 2 and 3 are strobes only and read back 0.
  - 2 PERIOD.
  - 3 SNAP. A write captures the counter value; a read returns the captured value.
- Writes are active only when chipselect=1 and write_n=0. Channel index ≥ NUM_CH: writes are ignored and reads return 0.
- Counter, when RUN=1 and a tick occurs:
  - count≠0: count ← count−1.
  - count=0: count ← PERIOD, TO ← 1; RUN ← 0 if CONT=0.
- Period P gives a timeout every P+1 ticks.
- PERIOD write: the register updates in the write cycle. In the next cycle the counter loads the new PERIOD and RUN ← 0, which is a forced reload and stop.
- START sets RUN=1 without reloading.
- STOP clears RUN and holds count.
- START and STOP in the same write: START wins.
- STATUS write and a timeout in the same cycle: TO ends at 1, so the set wins and no event is lost.
- START and a forced reload in the same cycle: START wins; the counter loads PERIOD and RUN=1.
- Channel irq = TO & ITO. `irq` is the OR over all channels.
- Unused upper bits of PERIOD, SNAP and readdata read as 0. Writedata bits above COUNTER_W are ignored.

## Timing
- Reset values:
  - readdata=0, irq=0.
  - Per channel: count=PERIOD=PERIOD_RST, CONTROL=0, RUN=0, TO=0, SNAP=0.
- Read latency: 1 cycle. readdata is registered every cycle from the current address, with no wait states.
- Write effect: register visible on the next edge. A forced reload completes one edge later.
- Tick: every clock, or the prescaler strobe (see Configuration).
- TO rises on the edge at which a running counter at 0 consumes a tick. irq follows combinationally from TO/ITO, so it appears in the same cycle as TO.
- Reset asserted mid-count: all state returns asynchronously to reset values; no pending events survive.

## Configuration
- TIMER_MC_PRESCALER_EN defined:
  - Adds global register PRESC, 16 bits, reset 0, at the highest address (all-ones address, channel NUM_CH−1 reserved if NUM_CH is a power of 2 → then NUM_CH ≤ 7).
  - A shared prescale counter asserts tick once every PRESC+1 clocks. A PRESC write restarts the prescaler at 0.
- Not defined: tick=1 every clock; no PRESC register; all addresses are channel registers.

## Structure
- Package `timer_mc_pkg`:
  - Offset constants OFS_STATUS/CONTROL/PERIOD/SNAP.
  - Control bit indices ITO/CONT/START/STOP; status bit indices TO/RUN.
  - PRESC register address function.
- Sub-module `timer_mc_channel`: one counter with its own PERIOD, CONTROL, STATUS and SNAP. Inputs: per-channel write strobes, writedata, tick. Outputs: read values, irq.
- Top level: address decode, read mux, readdata register, irq OR, and the optional prescaler.

## Test plan
- Reset, then read ch0 PERIOD → 49999 one cycle after the address is presented. irq=0.
- ch0 PERIOD=3, CONTROL=0x7 (START|CONT|ITO) → TO/irq every 4 clocks. STATUS write clears irq. A clear coinciding with a timeout leaves TO=1.
- ch1 PERIOD=5, CONTROL=0x4 (one-shot) → TO after 6 clocks; RUN=0; the counter reads back 5 via a SNAP write followed by a SNAP read.
- While ch0 is running, write ch0 PERIOD=10 → RUN=0 next cycle and count=10. ch1 is unaffected.
- CONTROL write of 0xC (START+STOP together) → RUN=1. A later write of 0x8 → RUN=0 and the count holds.
- With TIMER_MC_PRESCALER_EN, PRESC=4 and PERIOD=1 → a timeout every 10 clocks. Assert reset_n low mid-count → all registers return to reset values immediately.

Source files
------------

// File: rtl/timer_mc_pkg.sv
// Shared constants for the multi-channel interval timer: register offsets,
// control/status bit positions and the PRESC register location.
package timer_mc_pkg;

    localparam logic [1:0] OFS_STATUS  = 2'd0;
    localparam logic [1:0] OFS_CONTROL = 2'd1;
    localparam logic [1:0] OFS_PERIOD  = 2'd2;
    localparam logic [1:0] OFS_SNAP    = 2'd3;

    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;

    localparam int unsigned STAT_TO  = 0;
    localparam int unsigned STAT_RUN = 1;

    localparam int unsigned PRESC_W = 16;

    // PRESC sits at the all-ones word address of an AW-bit address space.
    function automatic logic [31:0] presc_addr(input int unsigned aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

endpackage

// File: rtl/timer_mc_channel.sv
// One timer channel: down-counter with PERIOD, CONTROL, STATUS and SNAP registers.
// A PERIOD write schedules a forced reload-and-stop on the following edge.
module timer_mc_channel
    import timer_mc_pkg::*;
#(
    parameter int unsigned COUNTER_W  = 32,
    parameter int unsigned PERIOD_RST = 49999
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic                 wr_status,
    input  logic                 wr_control,
    input  logic                 wr_period,
    input  logic                 wr_snap,
    input  logic [COUNTER_W-1:0] wdata,
    output logic [1:0]           status,
    output logic [1:0]           control,
    output logic [COUNTER_W-1:0] period,
    output logic [COUNTER_W-1:0] snap,
    output logic                 irq
);

    logic [COUNTER_W-1:0] count_q, count_d;
    logic [COUNTER_W-1:0] period_q, period_d;
    logic [COUNTER_W-1:0] snap_q, snap_d;
    logic                 run_q, run_d;
    logic                 to_q, to_d;
    logic                 ito_q, ito_d;
    logic                 cont_q, cont_d;
    logic                 reload_q, reload_d;
    logic                 timeout;

    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        snap_d   = snap_q;
        run_d    = run_q;
        to_d     = to_q;
        ito_d    = ito_q;
        cont_d   = cont_q;
        reload_d = wr_period;
        timeout  = 1'b0;

        if (reload_q) begin
            count_d = period_q;
            run_d   = 1'b0;
        end else if (run_q && tick) begin
            if (count_q == '0) begin
                count_d = period_q;
                timeout = 1'b1;
                if (!cont_q) begin
                    run_d = 1'b0;
                end
            end else begin
                count_d = count_q - COUNTER_W'(1);
            end
        end

        if (wr_period) begin
            period_d = wdata;
        end
        // Control writes come after the reload so START overrides a forced stop.
        if (wr_control) begin
            ito_d  = wdata[CTRL_ITO];
            cont_d = wdata[CTRL_CONT];
            if (wdata[CTRL_START]) begin
                run_d = 1'b1;
            end else if (wdata[CTRL_STOP]) begin
                run_d = 1'b0;
            end
        end
        if (wr_snap) begin
            snap_d = count_q;
        end
        if (wr_status) begin
            to_d = 1'b0;
        end
        if (timeout) begin
            to_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= COUNTER_W'(PERIOD_RST);
            period_q <= COUNTER_W'(PERIOD_RST);
            snap_q   <= '0;
            run_q    <= 1'b0;
            to_q     <= 1'b0;
            ito_q    <= 1'b0;
            cont_q   <= 1'b0;
            reload_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            period_q <= period_d;
            snap_q   <= snap_d;
            run_q    <= run_d;
            to_q     <= to_d;
            ito_q    <= ito_d;
            cont_q   <= cont_d;
            reload_q <= reload_d;
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^wdata;

    assign status[STAT_TO]    = to_q;
    assign status[STAT_RUN]   = run_q;
    assign control[CTRL_ITO]  = ito_q;
    assign control[CTRL_CONT] = cont_q;
    assign period             = period_q;
    assign snap               = snap_q;
    assign irq                = to_q & ito_q;

endmodule

// File: rtl/timer_mc.sv
// Multi-channel interval timer, Avalon-MM slave with registered reads and one level irq.
// Define TIMER_MC_PRESCALER_EN to add the shared PRESC tick prescaler at the all-ones address.
module timer_mc
    import timer_mc_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned COUNTER_W  = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned PERIOD_RST = 49999,
    localparam int unsigned AW        = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AW-1:0]     address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    logic                 wr_en;
    logic [31:0]          ch_idx;
    logic [1:0]           ofs;
    logic                 tick;
    logic                 is_presc;
    logic [NUM_CH-1:0]    ch_irq;
    logic [1:0]           ch_status  [NUM_CH];
    logic [1:0]           ch_control [NUM_CH];
    logic [COUNTER_W-1:0] ch_period  [NUM_CH];
    logic [COUNTER_W-1:0] ch_snap    [NUM_CH];
    logic [DATA_W-1:0]    readdata_d;
    logic                 unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign ch_idx       = 32'(address >> 2);
    assign ofs          = address[1:0];
    assign unused_wdata = ^writedata;

`ifdef TIMER_MC_PRESCALER_EN
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] pcnt_q;

    // PRESC shadows the top channel's SNAP slot when NUM_CH is a power of two.
    assign is_presc = (32'(address) == presc_addr(AW));
    assign tick     = (pcnt_q == presc_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            pcnt_q  <= '0;
        end else if (wr_en && is_presc) begin
            presc_q <= writedata[PRESC_W-1:0];
            pcnt_q  <= '0;
        end else if (tick) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + PRESC_W'(1);
        end
    end
`else
    assign is_presc = 1'b0;
    assign tick     = 1'b1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = wr_en && !is_presc && (ch_idx == 32'(i));

        timer_mc_channel #(
            .COUNTER_W  (COUNTER_W),
            .PERIOD_RST (PERIOD_RST)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .tick       (tick),
            .wr_status  (sel && ofs == OFS_STATUS),
            .wr_control (sel && ofs == OFS_CONTROL),
            .wr_period  (sel && ofs == OFS_PERIOD),
            .wr_snap    (sel && ofs == OFS_SNAP),
            .wdata      (writedata[COUNTER_W-1:0]),
            .status     (ch_status[i]),
            .control    (ch_control[i]),
            .period     (ch_period[i]),
            .snap       (ch_snap[i]),
            .irq        (ch_irq[i])
        );
    end

    always_comb begin
        readdata_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_idx == i) begin
                case (ofs)
                    OFS_STATUS:  readdata_d = DATA_W'(ch_status[i]);
                    OFS_CONTROL: readdata_d = DATA_W'(ch_control[i]);
                    OFS_PERIOD:  readdata_d = DATA_W'(ch_period[i]);
                    default:     readdata_d = DATA_W'(ch_snap[i]);
                endcase
            end
        end
`ifdef TIMER_MC_PRESCALER_EN
        if (is_presc) begin
            readdata_d = DATA_W'(presc_q);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= readdata_d;
        end
    end

    assign irq = |ch_irq;

endmodule

// File: tb/tb_timer_mc.sv
// Directed bench for timer_mc; covers the prescaler too when TIMER_MC_PRESCALER_EN is defined.
module tb_timer_mc;

`ifdef TIMER_MC_PRESCALER_EN
    localparam int unsigned NUM_CH = 3;
`else
    localparam int unsigned NUM_CH = 2;
`endif
    localparam int unsigned AW = $clog2(NUM_CH) + 2;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          irq;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] d;

    timer_mc #(
        .NUM_CH     (NUM_CH),
        .COUNTER_W  (32),
        .DATA_W     (32),
        .PERIOD_RST (49999)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write lands on the posedge between two negedges; returns at the following negedge.
    task automatic wr(input int unsigned a, input int unsigned v);
        @(negedge clk);
        address    = AW'(a);
        writedata  = v;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input int unsigned a, output logic [31:0] v);
        @(negedge clk);
        address    = AW'(a);
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        v          = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        repeat (2) @(negedge clk);
        check("rst_irq", 32'(irq), 0);
        check("rst_readdata", readdata, 0);
        reset_n = 1'b1;

        rd(2, d); check("rst_ch0_period", d, 49999);
        rd(6, d); check("rst_ch1_period", d, 49999);
        rd(0, d); check("rst_ch0_status", d, 0);
        rd(1, d); check("rst_ch0_control", d, 0);

        // ch0 continuous, period 3: timeout every 4 clocks
        wr(2, 3);
        wr(1, 7);
        repeat (3) @(negedge clk);
        check("ch0_irq_before_to", 32'(irq), 0);
        @(negedge clk);
        check("ch0_irq_at_to", 32'(irq), 1);
        wr(0, 0);
        check("ch0_irq_cleared", 32'(irq), 0);
        wr(0, 0);
        check("ch0_clear_vs_to", 32'(irq), 1);
        rd(0, d); check("ch0_status_to_run", d, 3);
        wr(1, 8);
        check("ch0_irq_ito_off", 32'(irq), 0);

        // ch1 one-shot, period 5
        wr(6, 5);
        wr(5, 4);
        address    = AW'(4);
        chipselect = 1'b0;
        repeat (6) @(negedge clk);
        check("ch1_status_pre_to", readdata, 2);
        @(negedge clk);
        check("ch1_status_to", readdata, 1);
        wr(7, 0);
        rd(7, d); check("ch1_snap_reload", d, 5);

        // PERIOD write while running forces reload and stop
        wr(1, 6);
        wr(2, 10);
        rd(0, d); check("ch0_run_after_reload", d & 32'h2, 0);
        wr(3, 0);
        rd(3, d); check("ch0_snap_reload", d, 10);
        rd(2, d); check("ch0_period_10", d, 10);
        rd(6, d); check("ch1_period_kept", d, 5);
        rd(4, d); check("ch1_status_kept", d, 1);

        // START+STOP together: START wins; later STOP holds the count
        wr(1, 12);
        rd(0, d); check("ch0_startstop_run", d & 32'h2, 2);
        rd(1, d); check("ch0_strobes_read0", d, 0);
        wr(1, 8);
        wr(3, 0);
        rd(3, d); check("ch0_stop_count", d, 4);
        repeat (3) @(negedge clk);
        wr(3, 0);
        rd(3, d); check("ch0_count_held", d, 4);

        // START coinciding with the forced reload
        @(negedge clk);
        address    = AW'(2);
        writedata  = 7;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        address    = AW'(1);
        writedata  = 4;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        wr(1, 8);
        wr(3, 0);
        rd(3, d); check("ch0_start_vs_reload", d, 5);

        // Asynchronous reset mid-count
        wr(1, 7);
        repeat (8) @(negedge clk);
        check("irq_pre_reset", 32'(irq), 1);
        address = AW'(2);
        @(negedge clk);
        check("readdata_pre_reset", readdata, 7);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_readdata", readdata, 0);
        check("async_rst_irq", 32'(irq), 0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2, d); check("post_rst_period", d, 49999);
        rd(0, d); check("post_rst_status", d, 0);
        rd(1, d); check("post_rst_control", d, 0);
        rd(3, d); check("post_rst_snap", d, 0);

`ifdef TIMER_MC_PRESCALER_EN
        rd(15, d); check("rst_presc", d, 0);
        rd(14, d); check("oob_read", d, 0);
        // PRESC=4, PERIOD=1: timeout every 10 clocks
        wr(15, 4);
        wr(2, 1);
        wr(1, 7);
        repeat (5) @(negedge clk);
        check("presc_irq_before", 32'(irq), 0);
        @(negedge clk);
        check("presc_irq_first", 32'(irq), 1);
        wr(0, 0);
        check("presc_irq_clr", 32'(irq), 0);
        repeat (7) @(negedge clk);
        check("presc_irq_gap", 32'(irq), 0);
        @(negedge clk);
        check("presc_irq_second", 32'(irq), 1);
        rd(15, d); check("presc_readback", d, 4);
        reset_n = 1'b0;
        #1;
        check("presc_rst_irq", 32'(irq), 0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(15, d); check("presc_after_rst", d, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
